// File: rtl/irq_ctrl_pkg.sv
// Shared constants and FSM encoding for the
// interrupt controller and its priority encoder.
package irq_ctrl_pkg;

    localparam int unsigned N_SRC_DEF     = 4;
    localparam logic [7:0]  BASE_ADDR_DEF = 8'hF0;

    localparam logic [7:0] OFF_MASK = 8'd0;
    localparam logic [7:0] OFF_PEND = 8'd1;
    localparam logic [7:0] OFF_VEC  = 8'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACKD
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the
// interrupt controller.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    // Scan downwards so the lowest set bit is the last to assign.
    always_comb begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: MASK/PENDING/VECTOR bus window
// plus IDLE/REQ/ACKD handshake towards the CPU.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC     = N_SRC_DEF,
    parameter logic [7:0]  BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic             CLK,
    input  logic             RESETN,
    inout  wire  [7:0]       BUS_DATA,
    input  logic [7:0]       BUS_ADDR,
    input  logic             BUS_WE,
    input  logic [N_SRC-1:0] SRC_IRQ,
    output logic [N_SRC-1:0] SRC_ACK,
    output logic             CPU_IRQ,
    input  logic             CPU_ACK
);

    localparam logic [7:0] A_MASK = BASE_ADDR + OFF_MASK;
    localparam logic [7:0] A_PEND = BASE_ADDR + OFF_PEND;
    localparam logic [7:0] A_VEC  = BASE_ADDR + OFF_VEC;

    irq_state_e       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic             rd_en_q, rd_en_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic [N_SRC-1:0] pend;
    logic [2:0]       enc_idx;
    logic             enc_valid;
    logic             sel_mask, sel_pend, sel_vec;
    logic             unused_bus;

    assign pend     = SRC_IRQ & mask_q;
    assign sel_mask = (BUS_ADDR == A_MASK);
    assign sel_pend = (BUS_ADDR == A_PEND);
    assign sel_vec  = (BUS_ADDR == A_VEC);

    assign unused_bus = ^BUS_DATA[7:N_SRC];

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_enc (
        .req_i   (pend),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        mask_d    = mask_q;
        rd_en_d   = 1'b0;
        rd_data_d = 8'h00;
        if (BUS_WE && sel_mask) begin
            mask_d = BUS_DATA[N_SRC-1:0];
        end
        if (!BUS_WE) begin
            rd_en_d = sel_mask | sel_pend | sel_vec;
            unique case (1'b1)
                sel_mask: rd_data_d = 8'(mask_q);
                sel_pend: rd_data_d = 8'(pend);
                sel_vec:  rd_data_d = {5'd0, vec_q};
                default:  rd_data_d = 8'h00;
            endcase
        end
    end

    // IDLE samples the pre-write MASK, since mask_q updates on the same edge.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d = REQ;
                    vec_d   = enc_idx;
                end
            end
            REQ: begin
                if (CPU_ACK) begin
                    state_d = ACKD;
                    ack_d   = N_SRC'(1) << vec_q;
                end
            end
            ACKD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            vec_q     <= 3'd0;
            mask_q    <= '0;
            ack_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            mask_q    <= mask_d;
            ack_q     <= ack_d;
            rd_en_q   <= rd_en_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;
    assign SRC_ACK  = ack_q;
    assign CPU_IRQ  = (state_q == REQ);

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: bus reads and SRC_ACK
// pulses are checked by a monitor against queued expectations.
module tb_irq_ctrl;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic [7:0]   addr;
    logic         we;
    logic [N-1:0] src;
    logic [N-1:0] sack;
    logic         cirq;
    logic         cack;
    logic [7:0]   drv;
    logic         oe;
    wire  [7:0]   bus;

    int checks = 0;
    int errors = 0;

    logic [7:0]   rd_q[$];
    logic [N-1:0] ack_q[$];

    // Undriven bus floats high through the pullup.
    assign bus = oe ? drv : 8'hzz;
    pullup pu_bus (bus);

    always #10 CLK = ~CLK;

    irq_ctrl u_dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .BUS_DATA (bus),
        .BUS_ADDR (addr),
        .BUS_WE   (we),
        .SRC_IRQ  (src),
        .SRC_ACK  (sack),
        .CPU_IRQ  (cirq),
        .CPU_ACK  (cack)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!oe && bus !== 8'hFF) begin
            if (rd_q.size() == 0)
                chk("unexpected bus drive", bus, 8'hFF);
            else
                chk("read data", bus, rd_q.pop_front());
        end
        if (sack !== '0) begin
            chk("src_ack onehot", 8'($countones(sack)), 8'd1);
            if (ack_q.size() == 0)
                chk("unexpected src_ack", 8'(sack), 8'h00);
            else
                chk("src_ack", 8'(sack), 8'(ack_q.pop_front()));
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we   = 1'b1;
        addr = a;
        drv  = d;
        oe   = 1'b1;
        tick();
        we   = 1'b0;
        oe   = 1'b0;
        addr = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, input bit has,
                      input logic [7:0] e);
        we   = 1'b0;
        addr = a;
        if (has) rd_q.push_back(e);
        tick();
        addr = 8'h00;
        if (!has) chk("hi-z data cycle", bus, 8'hFF);
        tick();
        if (!has) chk("hi-z after", bus, 8'hFF);
    endtask

    task automatic ack(input logic [N-1:0] e);
        ack_q.push_back(e);
        cack = 1'b1;
        tick();
        cack = 1'b0;
    endtask

    initial begin
        oe   = 1'b0;
        drv  = 8'h00;
        addr = 8'h00;
        we   = 1'b0;
        src  = '0;
        cack = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset cpu_irq", 8'(cirq), 8'h00);
        chk("reset src_ack", 8'(sack), 8'h00);
        chk("reset bus hi-z", bus, 8'hFF);
        RESETN = 1'b1;
        tick();

        // Single source, full handshake
        wr(8'hF0, 8'h0F);
        src = 4'b0001;
        chk("t1 irq before edge", 8'(cirq), 8'h00);
        tick();
        chk("t1 irq raised", 8'(cirq), 8'h01);
        rd(8'hF2, 1'b1, 8'h00);
        rd(8'hF1, 1'b1, 8'h01);
        ack(4'b0001);
        chk("t1 irq in ackd", 8'(cirq), 8'h00);
        src = 4'b0000;
        tick();
        chk("t1 irq idle", 8'(cirq), 8'h00);

        // Two simultaneous sources, priority order
        src = 4'b1010;
        tick();
        chk("t2 irq round1", 8'(cirq), 8'h01);
        rd(8'hF2, 1'b1, 8'h01);
        ack(4'b0010);
        src = 4'b1000;
        chk("t2 irq ackd", 8'(cirq), 8'h00);
        tick();
        chk("t2 irq idle gap", 8'(cirq), 8'h00);
        tick();
        chk("t2 irq round2", 8'(cirq), 8'h01);
        rd(8'hF2, 1'b1, 8'h03);
        ack(4'b1000);
        src = 4'b0000;
        tick();

        // Masked sources, then unmask; write races a request
        wr(8'hF0, 8'h00);
        src = 4'b1111;
        tick();
        chk("t3 masked irq", 8'(cirq), 8'h00);
        rd(8'hF1, 1'b1, 8'h00);
        wr(8'hF0, 8'h04);
        chk("t3 old mask used", 8'(cirq), 8'h00);
        tick();
        chk("t3 unmasked irq", 8'(cirq), 8'h01);
        rd(8'hF2, 1'b1, 8'h02);
        rd(8'hF0, 1'b1, 8'h04);
        ack(4'b0100);
        src = 4'b1011;
        tick();
        tick();
        chk("t3 src2 gone", 8'(cirq), 8'h00);

        // Mask cleared while in REQ keeps the request
        wr(8'hF0, 8'h0F);
        chk("t4 old mask zero pend", 8'(cirq), 8'h00);
        tick();
        chk("t4 irq vec0", 8'(cirq), 8'h01);
        rd(8'hF2, 1'b1, 8'h00);
        wr(8'hF0, 8'h00);
        chk("t4 irq held", 8'(cirq), 8'h01);
        ack(4'b0001);
        src = 4'b0000;
        tick();
        tick();
        chk("t4 irq idle", 8'(cirq), 8'h00);
        cack = 1'b1;
        tick();
        cack = 1'b0;
        chk("t4 stray ack", 8'(sack), 8'h00);
        tick();
        chk("t4 stray ack after", 8'(sack), 8'h00);

        // Reset in the middle of a handshake
        wr(8'hF0, 8'h0F);
        src = 4'b0100;
        tick();
        chk("t5 irq before reset", 8'(cirq), 8'h01);
        RESETN = 1'b0;
        cack   = 1'b1;
        #1;
        chk("t5 irq async clear", 8'(cirq), 8'h00);
        chk("t5 no ack in reset", 8'(sack), 8'h00);
        tick();
        cack   = 1'b0;
        RESETN = 1'b1;
        tick();
        chk("t5 masked after reset", 8'(cirq), 8'h00);
        rd(8'hF0, 1'b1, 8'h00);
        rd(8'hF2, 1'b1, 8'h00);
        src = 4'b0000;

        // Undecoded addresses never drive the bus
        rd(8'hF3, 1'b0, 8'h00);
        rd(8'hE0, 1'b0, 8'h00);

        repeat (3) tick();
        chk("read queue drained", 8'(rd_q.size()), 8'd0);
        chk("ack queue drained", 8'(ack_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
